// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared widths and state encodings for the softmax datapath
package softmax_pkg;

  localparam int DATALENGTH = 32;
  localparam int INPUTMAX   = 5;
  localparam int FRACBITS   = 16;

  localparam int IDXW = (INPUTMAX > 1) ? $clog2(INPUTMAX) : 1;
  localparam int SUMW = DATALENGTH + $clog2(INPUTMAX);
  localparam int QW   = FRACBITS + 1;
  localparam int DIVW = DATALENGTH + FRACBITS;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    INPUTSTREAM = 2'b01,
    OP          = 2'b10
  } state_t;

endpackage

// File: rtl/softmax_normalize_divider.sv
// rtl/softmax_normalize_divider.sv - restoring divider, one quotient bit per cycle
module serial_divider #(
  parameter int DW = 48,
  parameter int VW = 35,
  parameter int QW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int CW = $clog2(QW + 1);

  logic [VW-1:0] rem;
  logic [QW-1:0] low;
  logic [QW-1:0] q;
  logic [VW-1:0] dvs;
  logic [CW-1:0] cnt;

  logic [VW:0]   shifted;
  logic          ge;
  logic [VW-1:0] rem_next;
  logic [QW-1:0] q_next;

  // The caller guarantees dividend < divisor << QW, so the upper part fits below the divisor.
  always_comb begin
    shifted  = {rem, low[QW-1]};
    ge       = (shifted >= {1'b0, dvs});
    rem_next = ge ? VW'(shifted - {1'b0, dvs}) : shifted[VW-1:0];
    q_next   = {q[QW-2:0], ge};
  end

  // done/quotient are valid during the final iteration so the caller can register them on that edge.
  assign done     = busy && (cnt == CW'(1));
  assign quotient = (dvs == '0) ? '0 : q_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      low  <= '0;
      q    <= '0;
      dvs  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start && !busy) begin
      rem  <= VW'(dividend >> QW);
      low  <= dividend[QW-1:0];
      q    <= '0;
      dvs  <= divisor;
      cnt  <= CW'(QW);
      busy <= 1'b1;
    end else if (busy) begin
      rem <= rem_next;
      low <= low << 1;
      q   <= q_next;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/softmax_normalize.sv
// rtl/softmax_normalize.sv - buffers a frame of exp() samples and emits each divided by the frame sum
module softmax_normalize
  import softmax_pkg::*;
(
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  InValid,
  input  logic [DATALENGTH-1:0] DataIn,
  output logic                  Ready,
  output logic                  OutValid,
  output logic [DATALENGTH-1:0] DataOut,
  output logic [IDXW-1:0]       OutIndex,
  output logic                  Done
);

  state_t                state;
  logic [IDXW-1:0]       count;
  logic [IDXW-1:0]       op_idx;
  logic [SUMW-1:0]       sum;
  logic [DATALENGTH-1:0] sample_buf [INPUTMAX];

  logic                  div_start;
  logic                  div_busy;
  logic                  div_done;
  logic [QW-1:0]         div_q;
  logic [DIVW-1:0]       div_dividend;

  assign div_dividend = {sample_buf[op_idx], {FRACBITS{1'b0}}};
  // A new element loads in the cycle right after the previous result, giving a FRACBITS+2 period.
  assign div_start    = (state == OP) && !div_busy && !Done;

  serial_divider #(
    .DW(DIVW),
    .VW(SUMW),
    .QW(QW)
  ) u_div (
    .clk     (Clock),
    .rst_n   (Reset),
    .start   (div_start),
    .dividend(div_dividend),
    .divisor (sum),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(div_q)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      count    <= '0;
      op_idx   <= '0;
      sum      <= '0;
      Ready    <= 1'b0;
      OutValid <= 1'b0;
      DataOut  <= '0;
      OutIndex <= '0;
      Done     <= 1'b0;
      for (int i = 0; i < INPUTMAX; i++) sample_buf[i] <= '0;
    end else begin
      OutValid <= 1'b0;
      Done     <= 1'b0;
      case (state)
        IDLE: begin
          Ready <= 1'b1;
          if (InValid && Ready) begin
            sample_buf[0] <= DataIn;
            sum           <= SUMW'(DataIn);
            count         <= IDXW'(1);
            if (INPUTMAX == 1) begin
              state <= OP;
              Ready <= 1'b0;
            end else begin
              state <= INPUTSTREAM;
            end
          end
        end
        INPUTSTREAM: begin
          if (InValid) begin
            sample_buf[count] <= DataIn;
            sum               <= sum + SUMW'(DataIn);
            count             <= count + IDXW'(1);
            if (count == IDXW'(INPUTMAX - 1)) begin
              state <= OP;
              Ready <= 1'b0;
            end
          end
        end
        OP: begin
          if (Done) begin
            state  <= IDLE;
            count  <= '0;
            op_idx <= '0;
            sum    <= '0;
            Ready  <= 1'b1;
          end else if (div_done) begin
            OutValid <= 1'b1;
            DataOut  <= DATALENGTH'(div_q);
            OutIndex <= op_idx;
            if (op_idx == IDXW'(INPUTMAX - 1)) Done <= 1'b1;
            else op_idx <= op_idx + IDXW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_normalize.sv
// tb/tb_softmax_normalize.sv - table-driven frames checked against a scoreboard of expected pulses
module tb_softmax_normalize;
  import softmax_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  in_valid = 1'b0;
  logic [DATALENGTH-1:0] data_in = '0;
  logic                  Ready;
  logic                  OutValid;
  logic [DATALENGTH-1:0] DataOut;
  logic [IDXW-1:0]       OutIndex;
  logic                  Done;

  softmax_normalize dut (
    .Clock   (clk),
    .Reset   (rst_n),
    .InValid (in_valid),
    .DataIn  (data_in),
    .Ready   (Ready),
    .OutValid(OutValid),
    .DataOut (DataOut),
    .OutIndex(OutIndex),
    .Done    (Done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    int          idx;
    bit          last;
  } exp_t;

  typedef struct {
    string            name;
    logic [4:0][31:0] d;
    logic [4:0][31:0] q;
    int               gap;
    bit               junk;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[6];
  int   cap_cyc = 0;
  int   last_pulse_cyc = 0;
  bit   ready_due = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, want, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0][31:0] d, input int i);
    logic [63:0] s;
    logic [63:0] n;
    s = '0;
    for (int k = 0; k < 5; k++) s += {32'b0, d[k]};
    n = {32'b0, d[i]} << 16;
    if (s == 0) return 32'h0;
    return 32'(n / s);
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (ready_due) begin
      ready_due = 1'b0;
      chk("ready_after_done", {63'b0, Ready}, 64'd1);
    end
    if (rst_n && OutValid === 1'b1) begin
      chk("no_x", {63'b0, $isunknown({DataOut, OutIndex, Done})}, 64'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {63'b0, OutValid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("data", {32'b0, DataOut}, {32'b0, e.data});
        chk("index", 64'(OutIndex), 64'(e.idx));
        chk("done", {63'b0, Done}, {63'b0, e.last});
        chk("spacing", 64'(cyc - (e.idx == 0 ? cap_cyc : last_pulse_cyc)), 64'd18);
        if (e.last) ready_due = 1'b1;
      end
      last_pulse_cyc = cyc;
    end else if (rst_n) begin
      chk("done_alone", {63'b0, Done}, 64'd0);
    end
  end

  task automatic push_frame(input logic [4:0][31:0] q);
    for (int i = 0; i < 5; i++) sb.push_back('{q[i], i, i == 4});
  endtask

  task automatic drive_frame(input logic [4:0][31:0] d, input int gap_max, input bit junk);
    for (int i = 0; i < 5; i++) begin
      int g;
      int w;
      g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      in_valid = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      w = 0;
      while (Ready !== 1'b1 && w < 200) begin @(posedge clk); #1; w++; end
      if (w >= 200) chk("ready_timeout", {63'b0, Ready}, 64'd1);
      in_valid = 1'b1;
      data_in  = d[i];
      @(posedge clk); #1;
    end
    cap_cyc  = cyc;
    in_valid = 1'b0;
    if (junk) begin
      for (int j = 0; j < 20; j++) begin
        in_valid = 1'b1;
        data_in  = $urandom;
        chk("ready_in_op", {63'b0, Ready}, 64'd0);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 400) begin @(posedge clk); #1; w++; end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_ready"}, {63'b0, Ready}, 64'd0);
    chk({tag, "_outvalid"}, {63'b0, OutValid}, 64'd0);
    chk({tag, "_dataout"}, {32'b0, DataOut}, 64'd0);
    chk({tag, "_outindex"}, 64'(OutIndex), 64'd0);
    chk({tag, "_done"}, {63'b0, Done}, 64'd0);
  endtask

  initial begin
    logic [4:0][31:0] uni;
    logic [4:0][31:0] uni_q;
    int w;

    uni   = {5{32'h00010000}};
    uni_q = {5{32'h00003333}};

    rst_n = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      in_valid = ~in_valid;
      data_in  = $urandom;
      @(negedge clk);
      chk_zero_outputs("reset");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("ready_after_reset", {63'b0, Ready}, 64'd1);
    chk("outvalid_after_reset", {63'b0, OutValid}, 64'd0);

    tbl[0] = '{"uniform", uni, uni_q, 0, 1'b0};
    tbl[1] = '{"onehot", {128'b0, 32'h00010000}, {128'b0, 32'h00010000}, 0, 1'b0};
    tbl[2] = '{"maxval", {5{32'hFFFFFFFF}}, uni_q, 0, 1'b0};
    tbl[3] = '{"allzero", '0, '0, 1, 1'b0};
    tbl[4] = '{"gapped_junk", uni, uni_q, 3, 1'b1};
    tbl[5].name = "random";
    tbl[5].gap  = 2;
    tbl[5].junk = 1'b1;
    for (int i = 0; i < 5; i++) tbl[5].d[i] = $urandom_range(0, 32'h00FFFFFF);
    for (int i = 0; i < 5; i++) tbl[5].q[i] = model(tbl[5].d, i);

    for (int r = 0; r < 6; r++) begin
      push_frame(tbl[r].q);
      drive_frame(tbl[r].d, tbl[r].gap, tbl[r].junk);
      wait_drain();
    end

    push_frame(uni_q);
    drive_frame(uni, 0, 1'b0);
    w = 0;
    while (sb.size() > 3 && w < 300) begin @(negedge clk); w++; end
    chk("mid_op_wait", 64'(sb.size()), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("mid_op_reset");
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (60) begin @(posedge clk); #1; end

    push_frame(uni_q);
    drive_frame(uni, 0, 1'b0);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
